// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction image loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LO,
    HI,
    WR,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  // Byte that opens every program image frame.
  localparam logic [7:0] START_BYTE = 8'hA5;

  // Non-payload bytes per frame: START, N and the checksum.
  localparam int FRAME_OVERHEAD = 3;

endpackage

// File: rtl/inst_loader.sv
// Byte-stream program loader. It takes a framed image of the form
// START, N, N x {LO, HI}, C and writes each instruction into a writable
// instruction memory. The CPU stays held until an image has been written and
// its checksum has verified.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int         A     = 8,
  parameter int         W     = 9,
  parameter logic [7:0] START = START_BYTE
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         cpu_hold,
  output logic         done,
  output logic         error,
  output logic [A:0]   words_loaded
);

  localparam int unsigned DEPTH = 2**A;

  loader_state_t state_q, state_d;
  logic [7:0]    n_q;      // instruction count of the current frame
  logic [7:0]    lo_q;     // low byte waiting for its HI partner
  logic [7:0]    sum_q;    // running checksum, mod 256
  logic          ready_d;

  logic          acc;
  logic [7:0]    sum_next;
  logic [15:0]   hi_ext;
  logic          hi_bad;
  logic          len_bad;
  logic          last_word;

  assign acc      = in_valid && in_ready;
  assign sum_next = sum_q + in_data;

  // HI bits at or above position W-8 must be zero. A logical right shift
  // exposes exactly those bits, and it also covers W=16 where none exist.
  assign hi_ext   = {8'h00, in_data} >> (W - 8);
  assign hi_bad   = |hi_ext;

  // An image longer than the memory is rejected before any write happens.
  assign len_bad  = 32'(in_data) > DEPTH;

  // The word being written in WR is the final one of the frame.
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(n_q);

  // State register; in_ready is a flop so it is low while reset is applied.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= ready_d;
    end
  end

  // Next-state logic; input is accepted in every state except WR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: if (acc && in_data == START) state_d = LEN;
      LEN: if (acc) begin
        if (in_data == 8'h00) state_d = CSUM;
        else if (len_bad)     state_d = ERR;
        else                  state_d = LO;
      end
      LO:   if (acc) state_d = HI;
      HI:   if (acc) state_d = hi_bad ? ERR : WR;
      WR:   state_d = last_word ? CSUM : LO;
      CSUM: if (acc) state_d = (sum_next == 8'h00) ? DONE : ERR;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != WR);
  end

  // Status and write strobe decode straight from the state.
  always_comb begin
    mem_we   = (state_q == WR);
    done     = (state_q == DONE);
    error    = (state_q == ERR);
    cpu_hold = (state_q != DONE);
  end

  // Datapath: the count, checksum, pending LO byte, write port and word counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      n_q          <= '0;
      lo_q         <= '0;
      sum_q        <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
    end else begin
      unique case (state_q)
        LEN: if (acc) begin
          n_q          <= in_data;
          sum_q        <= in_data;
          words_loaded <= '0;
          mem_addr     <= '0;
        end
        LO: if (acc) begin
          lo_q  <= in_data;
          sum_q <= sum_next;
        end
        // mem_addr already points at the next free word (cleared in LEN,
        // advanced in WR), so only the data needs capturing here.
        HI: if (acc && !hi_bad) begin
          mem_wdata <= W'({in_data, lo_q});
          sum_q     <= sum_next;
        end
        WR: begin
          mem_addr     <= mem_addr + 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        CSUM: if (acc) sum_q <= sum_next;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader. Expected memory writes are queued as
// frames are sent and matched against every mem_we pulse.
module tb_inst_loader;
  localparam int A = 8;
  localparam int W = 9;

  typedef struct packed {
    logic [A-1:0] addr;
    logic [W-1:0] data;
  } wr_t;

  logic         Clk = 1'b0;
  logic         Reset_n = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready, mem_we, cpu_hold, done, error;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [A:0]   words_loaded;

  int compared = 0;
  int mismatched = 0;
  int writes = 0;
  int ready_low = 0;
  wr_t exp_q[$];
  logic [W-1:0] mem [2**A];

  inst_loader #(.A(A), .W(W), .START(8'hA5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 Clk = ~Clk;

  // Write monitor: pop the scoreboard on each write, mirror it into a memory model.
  always @(negedge Clk) begin
    wr_t e;
    if (Reset_n) begin
      if (!in_ready) ready_low++;
      if (mem_we) begin
        writes++;
        mem[mem_addr] = mem_wdata;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_write addr=%0h data=%0h", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            mismatched++;
            $display("FAIL write got %0h:%0h expected %0h:%0h", mem_addr, mem_wdata, e.addr, e.data);
          end
        end
        compared++;
        if (in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL we_with_ready in_ready=%b expected 0", in_ready);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge Clk);
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge Clk);
      t++;
    end
    if (t >= 50) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout byte=%0h in_ready stuck at %b", b, in_ready);
    end
    @(posedge Clk);
    #1 in_valid = 1'b0;
  endtask

  // Sends a complete frame; the checksum is derived so that the total sums to zero.
  task automatic send_frame(input logic [7:0] n, input logic [7:0] lo[4], input logic [7:0] hi[4]);
    logic [7:0] s;
    s = n;
    for (int i = 0; i < n; i++) begin
      s = s + lo[i] + hi[i];
      exp_q.push_back('{addr: A'(i), data: W'({hi[i], lo[i]})});
    end
    send(8'hA5);
    send(n);
    for (int i = 0; i < n; i++) begin
      send(lo[i]);
      send(hi[i]);
    end
    send(8'h00 - s);
  endtask

  task automatic test_reset;
    #1 Reset_n = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== '0) begin
      mismatched++;
      $display("FAIL reset_values rdy=%b we=%b addr=%0h wd=%0h hold=%b done=%b err=%b wl=%0d expected 0,0,0,0,1,0,0,0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded);
    end
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_one_word;
    logic [7:0] lo[4] = '{8'hFF, 8'h00, 8'h00, 8'h00};
    logic [7:0] hi[4] = '{8'h01, 8'h00, 8'h00, 8'h00};
    writes = 0;
    send_frame(8'd1, lo, hi);
    @(negedge Clk);
    compared++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || words_loaded !== 9'd1) begin
      mismatched++;
      $display("FAIL one_word_status done=%b hold=%b err=%b wl=%0d expected 1,0,0,1", done, cpu_hold, error, words_loaded);
    end
    compared++;
    if (writes !== 1 || exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL one_word_writes got %0d pending %0d expected 1 and 0", writes, exp_q.size());
    end
  endtask

  task automatic test_three_word;
    logic [7:0] lo[4] = '{8'h10, 8'h20, 8'h30, 8'h00};
    logic [7:0] hi[4] = '{8'h00, 8'h01, 8'h00, 8'h00};
    writes = 0;
    ready_low = 0;
    send_frame(8'd3, lo, hi);
    @(negedge Clk);
    compared++;
    if (ready_low !== 3) begin
      mismatched++;
      $display("FAIL three_word_ready_low got %0d cycles expected 3", ready_low);
    end
    compared++;
    if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 9'd3 || writes !== 3) begin
      mismatched++;
      $display("FAIL three_word_status done=%b err=%b wl=%0d writes=%0d expected 1,0,3,3", done, error, words_loaded, writes);
    end
    compared++;
    if (mem[1] !== 9'h120) begin
      mismatched++;
      $display("FAIL three_word_mem1 got %0h expected 120", mem[1]);
    end
  endtask

  // A new START straight out of DONE drops done and raises cpu_hold one cycle later.
  task automatic test_back_to_back;
    writes = 0;
    send(8'hA5);
    compared++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_restart done=%b hold=%b expected 0,1", done, cpu_hold);
    end
    exp_q.push_back('{addr: 8'h00, data: 9'h007});
    send(8'h01); send(8'h07); send(8'h00); send(8'hF8);
    @(negedge Clk);
    compared++;
    if (done !== 1'b1 || words_loaded !== 9'd1 || writes !== 1) begin
      mismatched++;
      $display("FAIL b2b_status done=%b wl=%0d writes=%0d expected 1,1,1", done, words_loaded, writes);
    end
  endtask

  task automatic test_bad_checksum;
    writes = 0;
    exp_q.push_back('{addr: 8'h00, data: 9'h005});
    send(8'hA5); send(8'h01); send(8'h05); send(8'h00); send(8'h00);
    @(negedge Clk);
    compared++;
    if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || writes !== 1) begin
      mismatched++;
      $display("FAIL bad_csum_status err=%b done=%b hold=%b writes=%0d expected 1,0,1,1", error, done, cpu_hold, writes);
    end
    send(8'hA5); send(8'h00); send(8'h00);
    @(negedge Clk);
    compared++;
    if (done !== 1'b1 || error !== 1'b0 || words_loaded !== '0) begin
      mismatched++;
      $display("FAIL bad_csum_recover done=%b err=%b wl=%0d expected 1,0,0", done, error, words_loaded);
    end
  endtask

  task automatic test_bad_hi;
    writes = 0;
    send(8'hA5); send(8'h02); send(8'h11); send(8'h02);
    @(negedge Clk);
    compared++;
    if (error !== 1'b1 || writes !== 0 || cpu_hold !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_hi_status err=%b writes=%0d hold=%b expected 1,0,1", error, writes, cpu_hold);
    end
    send(8'h33); send(8'h44); send(8'h00);
    @(negedge Clk);
    compared++;
    if (error !== 1'b1 || writes !== 0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL bad_hi_discard err=%b writes=%0d rdy=%b expected 1,0,1", error, writes, in_ready);
    end
  endtask

  task automatic test_empty_stall;
    writes = 0;
    send(8'h3C);
    @(negedge Clk);
    compared++;
    if (error !== 1'b1) begin
      mismatched++;
      $display("FAIL garbage_ignored err=%b expected 1", error);
    end
    send(8'hA5);
    repeat (3) @(negedge Clk);
    compared++;
    if (error !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_len err=%b done=%b rdy=%b expected 0,0,1", error, done, in_ready);
    end
    send(8'h00);
    repeat (2) @(negedge Clk);
    compared++;
    if (done !== 1'b0 || error !== 1'b0) begin
      mismatched++;
      $display("FAIL stall_csum done=%b err=%b expected 0,0", done, error);
    end
    send(8'h00);
    @(negedge Clk);
    compared++;
    if (done !== 1'b1 || words_loaded !== '0 || writes !== 0) begin
      mismatched++;
      $display("FAIL empty_status done=%b wl=%0d writes=%0d expected 1,0,0", done, words_loaded, writes);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] lo[4] = '{8'h40, 8'h50, 8'h60, 8'h00};
    logic [7:0] hi[4] = '{8'h01, 8'h00, 8'h01, 8'h00};
    exp_q.push_back('{addr: 8'h00, data: 9'h010});
    send(8'hA5); send(8'h03); send(8'h10); send(8'h00); send(8'h20);
    #2 Reset_n = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || words_loaded !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_values rdy=%b we=%b addr=%0h wd=%0h hold=%b done=%b err=%b wl=%0d expected 0,0,0,0,1,0,0,0",
               in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error, words_loaded);
    end
    compared++;
    if (mem[0] !== 9'h010) begin
      mismatched++;
      $display("FAIL mid_reset_word0 got %0h expected 010", mem[0]);
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    writes = 0;
    send_frame(8'd3, lo, hi);
    @(negedge Clk);
    compared++;
    if (done !== 1'b1 || words_loaded !== 9'd3 || writes !== 3 || mem[0] !== 9'h140 || mem[2] !== 9'h160) begin
      mismatched++;
      $display("FAIL reload done=%b wl=%0d writes=%0d m0=%0h m2=%0h expected 1,3,3,140,160",
               done, words_loaded, writes, mem[0], mem[2]);
    end
  endtask

  initial begin
    test_reset();
    test_one_word();
    test_three_word();
    test_back_to_back();
    test_bad_checksum();
    test_bad_hi();
    test_empty_stall();
    test_reset_mid();
    compared++;
    if (exp_q.size() !== 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
